uart_tx_queue: RTL and testbench
================================

Name: uart_tx_queue

Overview:
- Buffered byte source for the UART transmitter; it drives the far end of the transmitter's tx_i / tx_byte_i / tx_dequeue_o interface.
- Accepts bytes from a host-side valid/ready write port into a show-ahead FIFO and presents the head byte to uart_tx.
- Pops a byte when uart_tx pulses tx_dequeue_o.
- Reports occupancy, a low-watermark interrupt and a sticky overflow flag, and supports flush.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- LOW_WM, 4, irq_low_o asserts when count <= LOW_WM; range 0..DEPTH-1.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_valid_i  input  1  host offers wr_data_i.
- wr_data_i  input  8  byte to enqueue.
- wr_ready_o  output  1  queue can accept a byte this cycle.
- flush_i  input  1  discard all queued bytes.
- clr_ovf_i  input  1  clear overflow_o.
- tx_o  output  1  head byte valid; connects to uart_tx tx_i.
- tx_byte_o  output  8  head byte; connects to uart_tx tx_byte_i.
- tx_dequeue_i  input  1  one-cycle pulse from uart_tx tx_dequeue_o; head byte consumed.
- count_o  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- irq_low_o  output  1  registered; count <= LOW_WM.
- overflow_o  output  1  sticky; a write was attempted while full.

Behaviour:
- Storage:
  - DEPTH x 8 register array.
  - Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is a separate $clog2(DEPTH)+1-bit register.
  - empty = (count==0); full = (count==DEPTH).
- Reset (clock edge with reset=1):
  - Pointers, count and overflow_o go to 0; irq_low_o goes to 1.
  - tx_o=0 and wr_ready_o=1 as a consequence.
  - Array contents are not reset.
  - Reset takes priority over every other input.
- wr_ready_o = !full && !flush_i. This is combinational from registered state plus flush_i, and does not depend on tx_dequeue_i.
- Push:
  - Occurs when wr_valid_i && wr_ready_o.
  - Writes wr_data_i at wptr; wptr increments.
- Pop:
  - Occurs when tx_dequeue_i && !empty && !flush_i; rptr increments.
  - tx_dequeue_i while empty is ignored; no pointer or count change.
- Show-ahead output:
  - tx_o = !empty; tx_byte_o = array[rptr], combinational read.
  - A byte pushed in cycle N is visible on tx_o / tx_byte_o in cycle N+1.
  - Zero extra latency beyond the write register.
- Count update:
  - +1 on push only; -1 on pop only.
  - Unchanged on simultaneous push and pop.
- Simultaneous push and pop:
  - Legal whenever not full and not empty.
  - When full, no push occurs even if a pop occurs the same cycle; the push is accepted the next cycle.
  - When empty, no pop can occur because tx_o=0.
- Flush:
  - On flush_i=1, the next edge sets rptr=wptr=0 and count=0.
  - Any concurrent push or pop is discarded.
  - A byte already captured by uart_tx finishes transmitting; the queue does not track it.
- Overflow:
  - overflow_o sets on the edge after any cycle with wr_valid_i && full && !flush_i.
  - Clears on clr_ovf_i.
  - If set and clear occur in the same cycle, set wins.
- irq_low_o:
  - Registered from the next-state count (count_next <= LOW_WM).
  - Level signal; no acknowledge.
- Host write port:
  - The host may hold wr_valid_i high with unchanging wr_data_i until accepted.
  - No combinational path from wr_valid_i to wr_ready_o.
- Pop interface:
  - tx_o must not drop while non-empty unless a flush or reset occurs.
  - tx_byte_o is stable until a pop.

Test Plan:
- Reset, then push 0x55, 0xA3, 0x0F back to back:
  - tx_o rises one cycle after the first push with tx_byte_o=0x55.
  - count_o steps 1,2,3.
  - Dequeue pulses yield 0xA3, then 0x0F, then tx_o=0 and count_o=0.
- Fill to DEPTH=16:
  - wr_ready_o=0 at count 16.
  - Extra write sets overflow_o=1.
  - One pop, then wr_ready_o=1 the next cycle.
  - clr_ovf_i clears the flag.
- Steady streaming, push and pop in the same cycle at count=5 for 40 cycles:
  - count_o holds 5.
  - Output byte order equals input order across pointer wrap (>=2 wraps).
- Flush at count=7 with concurrent push and dequeue:
  - Next cycle count_o=0, tx_o=0, irq_low_o=1.
  - Pushed byte discarded.
  - Next pushed byte appears as the head.
- Watermark with LOW_WM=4:
  - irq_low_o goes 1→0 on the edge that brings count to 5, and 0→1 on the pop returning count to 4.
  - Dequeue pulse while empty leaves count_o=0 with no underflow.
- Mid-operation reset at count=9 with wr_valid_i high:
  - After the reset edge: count_o=0, tx_o=0, overflow_o=0, wr_ready_o=1.
  - Write is accepted on the first cycle after reset deasserts.

Source files
------------

// File: rtl/uart_tx_queue_if.sv
// Host write port, queue control/status and the show-ahead byte port toward uart_tx.
// master = host/transmitter side, slave = the queue itself.
interface uart_tx_queue_if #(
    parameter int unsigned DEPTH = 16
);
    logic                     wr_valid_i;
    logic [7:0]               wr_data_i;
    logic                     wr_ready_o;
    logic                     flush_i;
    logic                     clr_ovf_i;
    logic                     tx_o;
    logic [7:0]               tx_byte_o;
    logic                     tx_dequeue_i;
    logic [$clog2(DEPTH):0]   count_o;
    logic                     irq_low_o;
    logic                     overflow_o;

    modport master (
        output wr_valid_i, wr_data_i, flush_i, clr_ovf_i, tx_dequeue_i,
        input  wr_ready_o, tx_o, tx_byte_o, count_o, irq_low_o, overflow_o
    );

    modport slave (
        input  wr_valid_i, wr_data_i, flush_i, clr_ovf_i, tx_dequeue_i,
        output wr_ready_o, tx_o, tx_byte_o, count_o, irq_low_o, overflow_o
    );
endinterface

// File: rtl/uart_tx_queue.sv
// Show-ahead byte FIFO feeding uart_tx: host valid/ready writes in, head byte out,
// popped by the transmitter's dequeue pulse. Reports occupancy, low watermark and overflow.
module uart_tx_queue #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned LOW_WM = 4
) (
    input  logic           clock,
    input  logic           reset,
    uart_tx_queue_if.slave q
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          overflow;
    logic          irq_low;

    logic empty;
    logic full;
    logic push;
    logic pop;

    always_comb begin
        empty = (count == '0);
        full  = (count == CW'(DEPTH));
        push  = q.wr_valid_i && !full && !q.flush_i;
        pop   = q.tx_dequeue_i && !empty && !q.flush_i;
    end

    always_comb begin
        count_next = count;
        if (q.flush_i) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rptr     <= '0;
            wptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            irq_low  <= 1'b1;
        end else begin
            if (q.flush_i) begin
                rptr <= '0;
                wptr <= '0;
            end else begin
                if (push) begin
                    wptr <= wptr + AW'(1);
                end
                if (pop) begin
                    rptr <= rptr + AW'(1);
                end
            end
            count   <= count_next;
            irq_low <= (count_next <= CW'(LOW_WM));
            // Set has priority over clear so a rejected write is never lost.
            if (q.wr_valid_i && full && !q.flush_i) begin
                overflow <= 1'b1;
            end else if (q.clr_ovf_i) begin
                overflow <= 1'b0;
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wptr] <= q.wr_data_i;
        end
    end

    always_comb begin
        q.wr_ready_o = !full && !q.flush_i;
        q.tx_o       = !empty;
        q.tx_byte_o  = mem[rptr];
        q.count_o    = count;
        q.irq_low_o  = irq_low;
        q.overflow_o = overflow;
    end
endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed self-checking bench for uart_tx_queue (DEPTH=16, LOW_WM=4).
module tb_uart_tx_queue;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] model [$];

    always #5 clock = ~clock;

    uart_tx_queue_if #(.DEPTH(16)) bus ();

    uart_tx_queue #(.DEPTH(16), .LOW_WM(4)) dut (
        .clock (clock),
        .reset (reset),
        .q     (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        bus.wr_valid_i = 1'b1;
        bus.wr_data_i  = d;
        tick();
        bus.wr_valid_i = 1'b0;
    endtask

    task automatic pop();
        bus.tx_dequeue_i = 1'b1;
        tick();
        bus.tx_dequeue_i = 1'b0;
    endtask

    initial begin
        bus.wr_valid_i   = 1'b0;
        bus.wr_data_i    = '0;
        bus.flush_i      = 1'b0;
        bus.clr_ovf_i    = 1'b0;
        bus.tx_dequeue_i = 1'b0;

        // Reset state
        tick();
        check("rst_count", 32'(bus.count_o), 0);
        check("rst_tx", 32'(bus.tx_o), 0);
        check("rst_irq", 32'(bus.irq_low_o), 1);
        check("rst_ovf", 32'(bus.overflow_o), 0);
        check("rst_ready", 32'(bus.wr_ready_o), 1);
        reset = 1'b0;

        // Back-to-back pushes then drain
        push(8'h55);
        check("t1_tx", 32'(bus.tx_o), 1);
        check("t1_head", 32'(bus.tx_byte_o), 32'h55);
        check("t1_cnt1", 32'(bus.count_o), 1);
        push(8'hA3);
        check("t1_cnt2", 32'(bus.count_o), 2);
        push(8'h0F);
        check("t1_cnt3", 32'(bus.count_o), 3);
        check("t1_head_hold", 32'(bus.tx_byte_o), 32'h55);
        pop();
        check("t1_pop1", 32'(bus.tx_byte_o), 32'hA3);
        check("t1_pop1_cnt", 32'(bus.count_o), 2);
        pop();
        check("t1_pop2", 32'(bus.tx_byte_o), 32'h0F);
        pop();
        check("t1_empty_tx", 32'(bus.tx_o), 0);
        check("t1_empty_cnt", 32'(bus.count_o), 0);

        // Fill to full, overflow, pop, clear
        for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
        check("t2_full_cnt", 32'(bus.count_o), 16);
        check("t2_full_ready", 32'(bus.wr_ready_o), 0);
        check("t2_full_irq", 32'(bus.irq_low_o), 0);
        check("t2_full_head", 32'(bus.tx_byte_o), 32'h10);
        push(8'hEE);
        check("t2_ovf_set", 32'(bus.overflow_o), 1);
        check("t2_ovf_cnt", 32'(bus.count_o), 16);
        pop();
        check("t2_pop_ready", 32'(bus.wr_ready_o), 1);
        check("t2_pop_cnt", 32'(bus.count_o), 15);
        check("t2_pop_head", 32'(bus.tx_byte_o), 32'h11);
        push(8'h20);
        check("t2_refill", 32'(bus.count_o), 16);
        bus.wr_valid_i = 1'b1;
        bus.clr_ovf_i  = 1'b1;
        tick();
        bus.wr_valid_i = 1'b0;
        check("t2_set_wins", 32'(bus.overflow_o), 1);
        tick();
        bus.clr_ovf_i = 1'b0;
        check("t2_ovf_clr", 32'(bus.overflow_o), 0);
        // Push+pop while full: only the pop happens, push lands next cycle
        bus.wr_valid_i   = 1'b1;
        bus.wr_data_i    = 8'h99;
        bus.tx_dequeue_i = 1'b1;
        tick();
        bus.tx_dequeue_i = 1'b0;
        check("t2_fullpp_cnt", 32'(bus.count_o), 15);
        check("t2_fullpp_ovf", 32'(bus.overflow_o), 1);
        tick();
        bus.wr_valid_i = 1'b0;
        check("t2_fullpp_push", 32'(bus.count_o), 16);
        check("t2_fullpp_head", 32'(bus.tx_byte_o), 32'h12);
        bus.flush_i   = 1'b1;
        bus.clr_ovf_i = 1'b1;
        tick();
        bus.flush_i   = 1'b0;
        bus.clr_ovf_i = 1'b0;
        check("t2_flush_cnt", 32'(bus.count_o), 0);
        check("t2_flush_ovf", 32'(bus.overflow_o), 0);

        // Streaming at count 5 across pointer wrap
        for (int i = 0; i < 5; i++) begin
            push(8'(8'hC0 + i));
            model.push_back(8'(8'hC0 + i));
        end
        for (int i = 0; i < 40; i++) begin
            logic [7:0] d;
            d = 8'(8'h30 + i * 7);
            check("t3_head", 32'(bus.tx_byte_o), 32'(model[0]));
            check("t3_ready", 32'(bus.wr_ready_o), 1);
            bus.wr_valid_i   = 1'b1;
            bus.wr_data_i    = d;
            bus.tx_dequeue_i = 1'b1;
            tick();
            void'(model.pop_front());
            model.push_back(d);
            check("t3_cnt", 32'(bus.count_o), 5);
        end
        bus.wr_valid_i   = 1'b0;
        bus.tx_dequeue_i = 1'b0;
        while (model.size() > 0) begin
            check("t3_drain", 32'(bus.tx_byte_o), 32'(model[0]));
            void'(model.pop_front());
            pop();
        end
        check("t3_drain_empty", 32'(bus.tx_o), 0);

        // Flush at count 7 with concurrent push and dequeue
        for (int i = 0; i < 7; i++) push(8'(8'h70 + i));
        check("t4_cnt7", 32'(bus.count_o), 7);
        bus.flush_i      = 1'b1;
        bus.wr_valid_i   = 1'b1;
        bus.wr_data_i    = 8'hEE;
        bus.tx_dequeue_i = 1'b1;
        #1;
        check("t4_ready_flush", 32'(bus.wr_ready_o), 0);
        tick();
        bus.flush_i      = 1'b0;
        bus.wr_valid_i   = 1'b0;
        bus.tx_dequeue_i = 1'b0;
        check("t4_cnt", 32'(bus.count_o), 0);
        check("t4_tx", 32'(bus.tx_o), 0);
        check("t4_irq", 32'(bus.irq_low_o), 1);
        push(8'h5A);
        check("t4_newhead", 32'(bus.tx_byte_o), 32'h5A);
        check("t4_newcnt", 32'(bus.count_o), 1);
        pop();

        // Low watermark edges
        for (int i = 0; i < 4; i++) begin
            push(8'(i));
            check("t5_irq_hi", 32'(bus.irq_low_o), 1);
        end
        push(8'h04);
        check("t5_cnt5", 32'(bus.count_o), 5);
        check("t5_irq_lo", 32'(bus.irq_low_o), 0);
        pop();
        check("t5_cnt4", 32'(bus.count_o), 4);
        check("t5_irq_back", 32'(bus.irq_low_o), 1);
        for (int i = 0; i < 4; i++) pop();
        pop();
        check("t5_underflow_cnt", 32'(bus.count_o), 0);
        check("t5_underflow_tx", 32'(bus.tx_o), 0);
        push(8'hB7);
        check("t5_after_empty_head", 32'(bus.tx_byte_o), 32'hB7);
        pop();

        // Mid-operation reset at count 9 with overflow set
        for (int i = 0; i < 16; i++) push(8'(i));
        push(8'hFF);
        check("t6_ovf", 32'(bus.overflow_o), 1);
        for (int i = 0; i < 7; i++) pop();
        check("t6_cnt9", 32'(bus.count_o), 9);
        bus.wr_valid_i = 1'b1;
        bus.wr_data_i  = 8'h77;
        reset = 1'b1;
        tick();
        check("t6_rst_cnt", 32'(bus.count_o), 0);
        check("t6_rst_tx", 32'(bus.tx_o), 0);
        check("t6_rst_ovf", 32'(bus.overflow_o), 0);
        check("t6_rst_ready", 32'(bus.wr_ready_o), 1);
        reset = 1'b0;
        tick();
        bus.wr_valid_i = 1'b0;
        check("t6_post_cnt", 32'(bus.count_o), 1);
        check("t6_post_head", 32'(bus.tx_byte_o), 32'h77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
